load_store_unit: RTL
====================

# load_store_unit

Initiator-side memory access controller for the single-cycle core's data path. It accepts byte, halfword and word load/store requests from the core with a valid/ready handshake. It drives the word-wide data memory port: word index address, combinational read data, single write enable, synchronous write. Sub-word stores are done as read-modify-write. Loads are aligned and sign- or zero-extended. Misaligned or illegal requests are reported as errors.

## Interface
- MEM_AW, default 12: width of the memory word index; the memory holds 2^MEM_AW 32-bit words.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - Stores accept 000/001/010 only.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse. No backpressure: the core must take it.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_error  out  1  qualifies rsp_valid; misaligned or illegal funct3.
- mem_address  out  32  word index {zeros, req_addr[MEM_AW+1:2]}.
- mem_write_data  out  32  full word to write.
- mem_write_enable  out  1  write strobe, sampled by memory on posedge clk.
- mem_read_data  in  32  combinational read of mem_address.

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- Request capture: on req_valid && req_ready, register write, funct3, addr and wdata.
  - If the request is illegal, go to RESP with rsp_error=1.
  - Otherwise go to ACCESS.
- Illegal conditions:
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - Load funct3 011/110/111.
  - Store funct3 other than 000/001/010.
- ACCESS: mem_address is driven from the registered address.
  - Load: extract the lane into rsp_rdata, then go to RESP.
    - Byte lane is addr[1:0]; half lane is addr[1].
    - B/H sign-extend; BU/HU zero-extend.
  - SW: mem_write_enable=1 and mem_write_data=wdata for this cycle only, then go to RESP.
  - SB/SH: capture mem_read_data into the merge register, then go to WRITE.
- WRITE (SB/SH only): mem_write_enable=1.
  - mem_write_data is the merge word with the addressed lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH).
  - All other lanes are unchanged.
  - Next state is RESP.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE.
- Address aliasing: req_addr bits above MEM_AW+1 are ignored, so upper addresses alias into the memory.
- mem_write_enable is asserted only in ACCESS (SW) or WRITE. It is never asserted for an errored request.

## Timing
- Cycle numbering: cycle 0 is the handshake cycle.
- Response latency:
  - Load and SW: rsp_valid in cycle 2.
  - SB/SH: rsp_valid in cycle 3.
  - Error: rsp_valid in cycle 1.
- Memory write commits:
  - SW: at the end of cycle 1.
  - SB/SH: at the end of cycle 2.
- req_ready is low from cycle 1 until the state returns to IDLE (the cycle after RESP). Throughput is one request per 3 (load/SW) or 4 (SB/SH) cycles.
- rsp_rdata and rsp_error hold their values until the next response. They are valid only with rsp_valid.
- Reset values (rst_n=0): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, mem_address=0, mem_write_data=0, mem_write_enable=0.
- Reset mid-operation: asserting rst_n in ACCESS or WRITE drops mem_write_enable immediately. No write occurs, the request is dropped, and no response is issued.

## Test plan
- Lane extraction: SW 0x4 = 0x8081_7F01, then:
  - LB 0x7 → 0xFFFF_FF80.
  - LBU 0x7 → 0x0000_0080.
  - LH 0x6 → 0xFFFF_8081.
  - LHU 0x4 → 0x0000_7F01.
  - LW 0x4 → 0x8081_7F01.
  - Each load's rsp_valid lands in cycle 2.
- Sub-word RMW:
  - Word 0x4 = 0x1122_3344; SB 0x5 with wdata 0x0000_00AA → word 0x1122_AA44.
  - Then SH 0x6 with wdata 0xBEEF → word 0xBEEF_AA44.
  - mem_write_enable is high for exactly one cycle, in cycle 2; rsp_valid is in cycle 3.
- Errors, each giving rsp_error=1, rsp_rdata=0, rsp_valid in cycle 1 and no mem_write_enable:
  - LW 0x2.
  - SH 0x3.
  - Store with funct3=100.
  - Memory remains unchanged after all three.
- Back-to-back: hold req_valid high over SW 0x0=0x1 then SW 0x8=0x2.
  - The second request is accepted only when req_ready returns high, after the first rsp_valid.
  - Readback returns 0x1 and 0x2.
- Reset during WRITE of SB 0x4: mem_write_enable falls immediately, the word is unchanged, and no rsp_valid is issued. After release, req_ready=1.
- Aliasing: SW 0x4004 = 0xCAFE_F00D; then LW 0x4 → 0xCAFE_F00D.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns core byte/half/word requests into accesses on a word-wide
// data memory port, with read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int MEM_AW = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        req_illegal;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] merged_word;
    logic        unused_addr_bits;

    // Address bits above the memory index alias and are deliberately dropped.
    assign unused_addr_bits = ^addr_q[31:MEM_AW+2];
    assign mem_address      = {{(32-MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};
    assign rsp_rdata        = rdata_q;
    assign rsp_error        = error_q;

    always_comb begin
        req_illegal = 1'b1;
        case (req_funct3)
            3'b000:         req_illegal = 1'b0;
            3'b001:         req_illegal = req_addr[0];
            3'b010:         req_illegal = |req_addr[1:0];
            3'b100:         req_illegal = req_write;
            3'b101:         req_illegal = req_write | req_addr[0];
            default:        req_illegal = 1'b1;
        endcase
    end

    always_comb begin
        load_byte = mem_read_data[7:0];
        case (addr_q[1:0])
            2'd0: load_byte = mem_read_data[7:0];
            2'd1: load_byte = mem_read_data[15:8];
            2'd2: load_byte = mem_read_data[23:16];
            2'd3: load_byte = mem_read_data[31:24];
            default: load_byte = mem_read_data[7:0];
        endcase
        load_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'd0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = mem_read_data;
        endcase
    end

    // funct3[0] separates SH (1) from SB (0); SW never reaches the merge path.
    always_comb begin
        merged_word = merge_q;
        if (funct3_q[0]) begin
            if (addr_q[1]) merged_word[31:16] = wdata_q[15:0];
            else           merged_word[15:0]  = wdata_q[15:0];
        end else begin
            case (addr_q[1:0])
                2'd0: merged_word[7:0]   = wdata_q[7:0];
                2'd1: merged_word[15:8]  = wdata_q[7:0];
                2'd2: merged_word[23:16] = wdata_q[7:0];
                2'd3: merged_word[31:24] = wdata_q[7:0];
                default: merged_word = merge_q;
            endcase
        end
    end

    // Response registers change only on entry to RESP so they hold between responses.
    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        funct3_d         = funct3_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        merge_d          = merge_q;
        rdata_d          = rdata_q;
        error_d          = error_q;
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        mem_write_enable = 1'b0;
        mem_write_data   = 32'd0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_illegal) begin
                        error_d = 1'b1;
                        rdata_d = 32'd0;
                        state_d = RESP;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!write_q) begin
                    rdata_d = load_data;
                    error_d = 1'b0;
                    state_d = RESP;
                end else if (funct3_q == 3'b010) begin
                    mem_write_enable = 1'b1;
                    mem_write_data   = wdata_q;
                    rdata_d          = 32'd0;
                    error_d          = 1'b0;
                    state_d          = RESP;
                end else begin
                    merge_d = mem_read_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_write_enable = 1'b1;
                mem_write_data   = merged_word;
                rdata_d          = 32'd0;
                error_d          = 1'b0;
                state_d          = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            merge_q  <= 32'd0;
            rdata_q  <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

endmodule
